stb_dcache_wr_responder: RTL and testbench

- dcache-side responder for the store-buffer write interface: accepts store requests from the store buffer and returns `dcache2stb_ack`.
- Holds a word-addressed data array with a parameterised write latency and applies byte-masked stores.
- Provides a one-cycle load port with a store-hazard stall, and a fence handshake that completes only when the store buffer is empty.
- Sits between the store buffer and the memory-side logic of the data cache.

---
 rtl/stb_dcache_pkg.sv | 20 ++
 rtl/stb_dcache_mem.sv | 43 ++++
 rtl/stb_dcache_wr_responder.sv | 136 +++++++++++++
 tb/tb_stb_dcache_wr_responder.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/stb_dcache_pkg.sv
// Shared types for the store-buffer / dcache write responder.
// Holds the store FSM state encoding and the word-index width helper.
// Ports: none (package only).
package stb_dcache_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Number of bits needed to index a DEPTH-word array (at least 1).
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int DEFAULT_DEPTH = 256;
  localparam int DEFAULT_IDX_W = idx_width(DEFAULT_DEPTH);

endpackage

// File: rtl/stb_dcache_mem.sv
// Word-organised data array: byte-enabled synchronous write, registered read.
// Latency: write lands at the clock edge; read data appears one cycle after rd_en.
// Ports: wr_en/wr_idx/wr_data/wr_be write port; rd_en/rd_idx in, rd_data out (holds when idle).
module stb_dcache_mem
  import stb_dcache_pkg::*;
#(
  parameter int DEPTH          = 256,
  parameter int DATA_WIDTH     = 32,
  parameter int BYTE_SEL_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [idx_width(DEPTH)-1:0] wr_idx,
  input  logic [DATA_WIDTH-1:0]     wr_data,
  input  logic [BYTE_SEL_WIDTH-1:0] wr_be,
  input  logic                      rd_en,
  input  logic [idx_width(DEPTH)-1:0] rd_idx,
  output logic [DATA_WIDTH-1:0]     rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Array contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < BYTE_SEL_WIDTH; i++) begin
        if (wr_be[i]) begin
          mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_idx];
    end
  end

endmodule

// File: rtl/stb_dcache_wr_responder.sv
// Dcache-side responder for store-buffer writes, plus a one-cycle load port and fence handshake.
// Latency: store ack WR_LATENCY cycles after acceptance; load data one cycle after an unstalled ld_req.
// Backpressure: one store in flight (req held until ack); loads to the in-flight word stall; fence waits for an idle, empty store path.
module stb_dcache_wr_responder
  import stb_dcache_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int BYTE_SEL_WIDTH = 4,
  parameter int DEPTH          = 256,
  parameter int WR_LATENCY     = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ADDR_WIDTH-1:0]     stb2dcache_addr,
  input  logic [DATA_WIDTH-1:0]     stb2dcache_wdata,
  input  logic [BYTE_SEL_WIDTH-1:0] stb2dcache_sel_byte,
  input  logic                      stb2dcache_w_en,
  input  logic                      stb2dcache_req,
  input  logic                      stb2dcache_empty,
  input  logic                      dmem_sel_i,
  output logic                      dcache2stb_ack,
  input  logic                      ld_req,
  input  logic [ADDR_WIDTH-1:0]     ld_addr,
  output logic [DATA_WIDTH-1:0]     ld_data,
  output logic                      ld_valid,
  output logic                      ld_stall,
  input  logic                      fence_req,
  output logic                      fence_ack
);

  localparam int IDX_W = idx_width(DEPTH);
  // Counter only ever holds values 0..WR_LATENCY-1.
  localparam int CNT_W = (WR_LATENCY > 1) ? $clog2(WR_LATENCY) : 1;

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q;
  logic [IDX_W-1:0]          lat_idx_q;
  logic [DATA_WIDTH-1:0]     lat_wdata_q;
  logic [BYTE_SEL_WIDTH-1:0] lat_sel_q;
  logic                      lat_dmem_q;

  logic [IDX_W-1:0] st_idx, ld_idx;
  logic             accept, hazard, ld_fire, mem_we;

  // Word index ignores the byte offset and everything above the array size,
  // so addresses wrap modulo DEPTH words.
  assign st_idx = stb2dcache_addr[IDX_W+1:2];
  assign ld_idx = ld_addr[IDX_W+1:2];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{stb2dcache_addr, ld_addr};

  assign accept  = (state_q == IDLE) && stb2dcache_req && stb2dcache_w_en;
  // A load of the word being written must wait until the write has landed,
  // i.e. it stays stalled through RESP and is serviced from the following cycle.
  assign hazard  = (state_q != IDLE) && lat_dmem_q && (ld_idx == lat_idx_q);
  assign ld_stall = ld_req && hazard;
  assign ld_fire  = ld_req && !hazard;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      lat_idx_q   <= '0;
      lat_wdata_q <= '0;
      lat_sel_q   <= '0;
      lat_dmem_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        lat_idx_q   <= st_idx;
        lat_wdata_q <= stb2dcache_wdata;
        lat_sel_q   <= stb2dcache_sel_byte;
        lat_dmem_q  <= dmem_sel_i;
        cnt_q       <= CNT_W'(WR_LATENCY - 1);
      end else if (state_q == WAIT) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    dcache2stb_ack = 1'b0;
    mem_we         = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = (WR_LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = RESP;
        end
      end
      RESP: begin
        dcache2stb_ack = 1'b1;
        mem_we         = lat_dmem_q;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_valid  <= 1'b0;
      fence_ack <= 1'b0;
    end else begin
      ld_valid  <= ld_fire;
      // The !fence_ack term keeps the ack to one cycle while the requester
      // is still reacting to it.
      fence_ack <= fence_req && stb2dcache_empty && (state_q == IDLE)
                   && !stb2dcache_req && !fence_ack;
    end
  end

  stb_dcache_mem #(
    .DEPTH         (DEPTH),
    .DATA_WIDTH    (DATA_WIDTH),
    .BYTE_SEL_WIDTH(BYTE_SEL_WIDTH)
  ) u_mem (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (mem_we),
    .wr_idx (lat_idx_q),
    .wr_data(lat_wdata_q),
    .wr_be  (lat_sel_q),
    .rd_en  (ld_fire),
    .rd_idx (ld_idx),
    .rd_data(ld_data)
  );

endmodule

// File: tb/tb_stb_dcache_wr_responder.sv
// Directed bench for stb_dcache_wr_responder (WR_LATENCY=2, DEPTH=256).
// Inputs driven 1ns after the rising edge; outputs sampled there or later.
// Ports: none (top-level bench).
module tb_stb_dcache_wr_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] stb2dcache_addr = '0;
  logic [31:0] stb2dcache_wdata = '0;
  logic [3:0]  stb2dcache_sel_byte = '0;
  logic        stb2dcache_w_en = 1'b0;
  logic        stb2dcache_req = 1'b0;
  logic        stb2dcache_empty = 1'b0;
  logic        dmem_sel_i = 1'b0;
  logic        dcache2stb_ack;
  logic        ld_req = 1'b0;
  logic [31:0] ld_addr = '0;
  logic [31:0] ld_data;
  logic        ld_valid;
  logic        ld_stall;
  logic        fence_req = 1'b0;
  logic        fence_ack;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  stb_dcache_wr_responder #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .BYTE_SEL_WIDTH(4),
    .DEPTH(256), .WR_LATENCY(2)
  ) dut (
    .clk(clk), .rst(rst),
    .stb2dcache_addr(stb2dcache_addr), .stb2dcache_wdata(stb2dcache_wdata),
    .stb2dcache_sel_byte(stb2dcache_sel_byte), .stb2dcache_w_en(stb2dcache_w_en),
    .stb2dcache_req(stb2dcache_req), .stb2dcache_empty(stb2dcache_empty),
    .dmem_sel_i(dmem_sel_i), .dcache2stb_ack(dcache2stb_ack),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_data(ld_data),
    .ld_valid(ld_valid), .ld_stall(ld_stall),
    .fence_req(fence_req), .fence_ack(fence_ack)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a store and wait (bounded) for its ack; lat counts edges from acceptance.
  task automatic run_store(input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input logic dm, output int lat);
    stb2dcache_addr = a; stb2dcache_wdata = d; stb2dcache_sel_byte = s;
    dmem_sel_i = dm; stb2dcache_w_en = 1'b1; stb2dcache_req = 1'b1;
    lat = 0;
    while (lat < 20) begin
      tick();
      lat++;
      if (dcache2stb_ack === 1'b1) break;
    end
    stb2dcache_req = 1'b0; stb2dcache_w_en = 1'b0;
  endtask

  // Issue a load, hold through any stall (bounded), return what comes back.
  task automatic run_load(input logic [31:0] a, output logic [31:0] data,
                          output logic valid, output int stalls);
    ld_req = 1'b1; ld_addr = a; stalls = 0;
    #1;
    while (ld_stall === 1'b1 && stalls < 20) begin
      stalls++;
      tick();
    end
    tick();
    valid = ld_valid; data = ld_data;
    ld_req = 1'b0;
  endtask

  task automatic test_reset();
    tick(); tick();
    total++; if (dcache2stb_ack !== 1'b0) begin bad++; $display("FAIL rst_ack got=%b exp=0", dcache2stb_ack); end
    total++; if (ld_valid !== 1'b0) begin bad++; $display("FAIL rst_ld_valid got=%b exp=0", ld_valid); end
    total++; if (ld_stall !== 1'b0) begin bad++; $display("FAIL rst_ld_stall got=%b exp=0", ld_stall); end
    total++; if (fence_ack !== 1'b0) begin bad++; $display("FAIL rst_fence_ack got=%b exp=0", fence_ack); end
    total++; if (ld_data !== 32'h0) begin bad++; $display("FAIL rst_ld_data got=%h exp=0", ld_data); end
    rst = 1'b0;
    tick();
    total++; if (dcache2stb_ack !== 1'b0) begin bad++; $display("FAIL post_rst_ack got=%b exp=0", dcache2stb_ack); end
  endtask

  task automatic test_full_store();
    int lat, st; logic [31:0] d; logic v;
    run_store(32'h10, 32'hDEADBEEF, 4'hF, 1'b1, lat);
    total++; if (lat !== 2) begin bad++; $display("FAIL full_ack_latency got=%0d exp=2", lat); end
    tick();
    total++; if (dcache2stb_ack !== 1'b0) begin bad++; $display("FAIL full_ack_width got=%b exp=0", dcache2stb_ack); end
    run_load(32'h10, d, v, st);
    total++; if (v !== 1'b1) begin bad++; $display("FAIL full_ld_valid got=%b exp=1", v); end
    total++; if (d !== 32'hDEADBEEF) begin bad++; $display("FAIL full_ld_data got=%h exp=deadbeef", d); end
    total++; if (st !== 0) begin bad++; $display("FAIL full_ld_stalls got=%0d exp=0", st); end
    tick();
    total++; if (ld_valid !== 1'b0) begin bad++; $display("FAIL full_ld_valid_pulse got=%b exp=0", ld_valid); end
  endtask

  task automatic test_byte_mask();
    int lat, st; logic [31:0] d; logic v;
    run_store(32'h10, 32'h11223344, 4'b0101, 1'b1, lat);
    total++; if (lat !== 2) begin bad++; $display("FAIL mask_ack_latency got=%0d exp=2", lat); end
    tick();
    run_load(32'h10, d, v, st);
    total++; if (d !== 32'hDE22BE44 || v !== 1'b1) begin bad++; $display("FAIL mask_ld_data got=%h/%b exp=de22be44/1", d, v); end
  endtask

  task automatic test_hazard();
    stb2dcache_addr = 32'h10; stb2dcache_wdata = 32'hCAFEF00D; stb2dcache_sel_byte = 4'hF;
    dmem_sel_i = 1'b1; stb2dcache_w_en = 1'b1; stb2dcache_req = 1'b1;
    tick();                       // accepted, now WAIT
    ld_req = 1'b1; ld_addr = 32'h10; #1;
    total++; if (ld_stall !== 1'b1) begin bad++; $display("FAIL haz_stall_wait got=%b exp=1", ld_stall); end
    ld_addr = 32'h20; #1;
    total++; if (ld_stall !== 1'b0) begin bad++; $display("FAIL haz_other_idx got=%b exp=0", ld_stall); end
    ld_addr = 32'h10; #1;
    tick();                       // RESP
    total++; if (dcache2stb_ack !== 1'b1) begin bad++; $display("FAIL haz_ack got=%b exp=1", dcache2stb_ack); end
    stb2dcache_req = 1'b0; stb2dcache_w_en = 1'b0;
    total++; if (ld_stall !== 1'b1) begin bad++; $display("FAIL haz_stall_resp got=%b exp=1", ld_stall); end
    tick();                       // IDLE, write landed
    total++; if (ld_stall !== 1'b0 || ld_valid !== 1'b0) begin bad++; $display("FAIL haz_release got=%b%b exp=00", ld_stall, ld_valid); end
    tick();
    total++; if (ld_valid !== 1'b1 || ld_data !== 32'hCAFEF00D) begin bad++; $display("FAIL haz_new_data got=%h/%b exp=cafef00d/1", ld_data, ld_valid); end
    ld_req = 1'b0;
    tick();
  endtask

  task automatic test_alias_sel_wen();
    int lat, st, acks; logic [31:0] d; logic v;
    run_store(32'h400, 32'h0A0B0C0D, 4'hF, 1'b1, lat);
    tick();
    run_load(32'h0, d, v, st);
    total++; if (d !== 32'h0A0B0C0D || v !== 1'b1) begin bad++; $display("FAIL alias_store got=%h exp=0a0b0c0d", d); end
    run_load(32'h410, d, v, st);
    total++; if (d !== 32'hCAFEF00D) begin bad++; $display("FAIL alias_load got=%h exp=cafef00d", d); end
    run_store(32'h0, 32'hFFFFFFFF, 4'hF, 1'b0, lat);
    total++; if (lat !== 2) begin bad++; $display("FAIL nodmem_ack_latency got=%0d exp=2", lat); end
    tick();
    run_load(32'h0, d, v, st);
    total++; if (d !== 32'h0A0B0C0D) begin bad++; $display("FAIL nodmem_unchanged got=%h exp=0a0b0c0d", d); end
    stb2dcache_addr = 32'h0; stb2dcache_wdata = 32'h77777777; dmem_sel_i = 1'b1;
    stb2dcache_w_en = 1'b0; stb2dcache_req = 1'b1; acks = 0;
    for (int i = 0; i < 6; i++) begin tick(); if (dcache2stb_ack === 1'b1) acks++; end
    stb2dcache_req = 1'b0;
    total++; if (acks !== 0) begin bad++; $display("FAIL wen0_no_ack got=%0d exp=0", acks); end
    // Load of another word while the RESP write is happening.
    stb2dcache_addr = 32'h10; stb2dcache_wdata = 32'hCAFEF00D; stb2dcache_sel_byte = 4'hF;
    stb2dcache_w_en = 1'b1; stb2dcache_req = 1'b1;
    tick(); tick();
    stb2dcache_req = 1'b0; stb2dcache_w_en = 1'b0;
    ld_req = 1'b1; ld_addr = 32'h0; #1;
    total++; if (ld_stall !== 1'b0 || dcache2stb_ack !== 1'b1) begin bad++; $display("FAIL resp_other_stall got=%b ack=%b exp=0/1", ld_stall, dcache2stb_ack); end
    tick();
    total++; if (ld_valid !== 1'b1 || ld_data !== 32'h0A0B0C0D) begin bad++; $display("FAIL resp_other_load got=%h/%b exp=0a0b0c0d/1", ld_data, ld_valid); end
    ld_req = 1'b0;
    tick();
  endtask

  task automatic test_fence();
    int acks = 0;
    stb2dcache_empty = 1'b0; fence_req = 1'b1;
    for (int i = 0; i < 5; i++) begin tick(); if (fence_ack === 1'b1) acks++; end
    total++; if (acks !== 0) begin bad++; $display("FAIL fence_not_empty got=%0d exp=0", acks); end
    stb2dcache_empty = 1'b1;
    tick();
    total++; if (fence_ack !== 1'b1) begin bad++; $display("FAIL fence_ack got=%b exp=1", fence_ack); end
    fence_req = 1'b0;
    tick();
    total++; if (fence_ack !== 1'b0) begin bad++; $display("FAIL fence_pulse got=%b exp=0", fence_ack); end
    // An outstanding store request blocks the fence.
    stb2dcache_req = 1'b1; stb2dcache_w_en = 1'b0; fence_req = 1'b1; acks = 0;
    for (int i = 0; i < 3; i++) begin tick(); if (fence_ack === 1'b1) acks++; end
    total++; if (acks !== 0) begin bad++; $display("FAIL fence_req_block got=%0d exp=0", acks); end
    stb2dcache_req = 1'b0;
    tick();
    total++; if (fence_ack !== 1'b1) begin bad++; $display("FAIL fence_after_req got=%b exp=1", fence_ack); end
    fence_req = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    int lat, st, acks = 0; logic [31:0] d; logic v;
    stb2dcache_addr = 32'h10; stb2dcache_wdata = 32'h55555555; stb2dcache_sel_byte = 4'hF;
    dmem_sel_i = 1'b1; stb2dcache_w_en = 1'b1; stb2dcache_req = 1'b1;
    tick();                       // in WAIT
    rst = 1'b1; stb2dcache_req = 1'b0; stb2dcache_w_en = 1'b0;
    for (int i = 0; i < 3; i++) begin #1; if (dcache2stb_ack === 1'b1) acks++; tick(); end
    total++; if (acks !== 0) begin bad++; $display("FAIL rstmid_no_ack got=%0d exp=0", acks); end
    rst = 1'b0;
    tick();
    run_load(32'h10, d, v, st);
    total++; if (d !== 32'hCAFEF00D) begin bad++; $display("FAIL rstmid_no_write got=%h exp=cafef00d", d); end
    run_store(32'h10, 32'h12345678, 4'hF, 1'b1, lat);
    total++; if (lat !== 2) begin bad++; $display("FAIL rstmid_new_latency got=%0d exp=2", lat); end
    tick();
    run_load(32'h10, d, v, st);
    total++; if (d !== 32'h12345678 || v !== 1'b1) begin bad++; $display("FAIL rstmid_new_data got=%h exp=12345678", d); end
  endtask

  initial begin
    test_reset();
    test_full_store();
    test_byte_mask();
    test_hazard();
    test_alias_sel_wen();
    test_fence();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
